// File: rtl/alu_share_arb.sv
// Round-robin scheduler sharing one ALU between two requesters, with a held response register.
// Optional macro ALU_ARB_MULCYC_EN stretches EXEC to MUL_LAT cycles for MUL ops.
module alu_share_arb #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_zero_o,
    output logic             rsp_id_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             grant0, grant1, accept, capture;
    logic [2:0]       sel_op;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q, rsp_id_q;

    // A tie goes to whichever requester did not win last time
    assign grant0 = req0_valid_i && (!req1_valid_i || last_grant_q);
    assign grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    assign accept = (state_q == IDLE) && (grant0 || grant1);
    assign sel_op = grant0 ? req0_op_i : req1_op_i;

`ifdef ALU_ARB_MULCYC_EN
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= (sel_op == 3'b101) ? MUL_CNT : 4'd1;
        end else if (state_q == EXEC && cnt_q != 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign capture = (state_q == EXEC) && (cnt_q == 4'd1);
`else
    localparam int mul_lat_unused = MUL_LAT;
    assign capture = (state_q == EXEC);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = EXEC;
            EXEC:    if (capture)     state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp_valid_o  = 1'b0;
        busy_o       = (state_q != IDLE);
        if (state_q == IDLE) begin
            req0_ready_o = grant0;
            req1_ready_o = grant1;
        end
        if (state_q == RESP) rsp_valid_o = 1'b1;
    end

    // Operand registers also drive the ALU, so its inputs hold their last values while idle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q         <= 3'd0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            op_q         <= sel_op;
            a_q          <= grant0 ? req0_a_i : req1_a_i;
            b_q          <= grant0 ? req0_b_i : req1_b_i;
            id_q         <= grant1;
            last_grant_q <= grant1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else if (capture) begin
            rsp_data_q <= alu_data_i;
            rsp_zero_q <= alu_zero_i;
            rsp_id_q   <= id_q;
        end
    end

    assign alu_data1_o = a_q;
    assign alu_data2_o = b_q;
    assign alu_ctrl_o  = op_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: behavioural ALU stub, arbitration model and response checker.
module tb_alu_share_arb;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic             req0_ready_o, req1_ready_o;
    logic [2:0]       req0_op_i = '0, req1_op_i = '0;
    logic [WIDTH-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]       alu_ctrl_o;
    logic             alu_zero_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [WIDTH-1:0] rsp_data_o;
    logic             rsp_zero_o, rsp_id_o, busy_o;

    alu_share_arb #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_zero_o(rsp_zero_o), .rsp_id_o(rsp_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a ^ b;
            3'b010:  return a << b[4:0];
            3'b011:  return a + b;
            3'b100:  return a - b;
            3'b101:  return 32'(a * b);
            3'b110:  return a + b;
            default: return 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        int lat = 2;
`ifdef ALU_ARB_MULCYC_EN
        if (op == 3'b101) lat = MUL_LAT + 1;
`else
        if (op == 3'b101) lat = 2;
`endif
        return lat;
    endfunction

    assign alu_data_i = ref_alu(alu_ctrl_o, alu_data1_o, alu_data2_o);
    assign alu_zero_i = (alu_data1_o == alu_data2_o);

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a, b, data;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0, cyc = 0;
    logic        model_last = 1'b1;
    bit          prev_valid = 0, prev_hold = 0, rand_ready = 0;
    logic [33:0] held = '0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: arbitration model, ALU drive, latency, hold-stability and response scoreboard
    always @(negedge clk_i) begin
        if (rst_i) begin
            automatic bit   idle = (sb.size() == 0);
            automatic logic g0 = req0_valid_i && req0_ready_o;
            automatic logic g1 = req1_valid_i && req1_ready_o;
            automatic exp_t e;
            check_output("ready0", req0_ready_o, idle && req0_valid_i && (!req1_valid_i || model_last));
            check_output("ready1", req1_ready_o, idle && req1_valid_i && (!req0_valid_i || !model_last));
            check_output("busy", busy_o, !idle);
            if (!idle) begin
                check_output("alu_ctrl", alu_ctrl_o, sb[0].op);
                check_output("alu_data1", alu_data1_o, sb[0].a);
                check_output("alu_data2", alu_data2_o, sb[0].b);
            end
            if (rsp_valid_o) begin
                if (idle) begin
                    check_output("spurious_rsp", rsp_valid_o, 1'b0);
                end else begin
                    if (!prev_valid) check_output("latency", cyc - sb[0].acc_cyc, exp_lat(sb[0].op));
                    if (prev_hold) check_output("rsp_hold", {rsp_id_o, rsp_zero_o, rsp_data_o}, held);
                    held = {rsp_id_o, rsp_zero_o, rsp_data_o};
                    prev_hold = !rsp_ready_i;
                    if (rsp_ready_i) begin
                        e = sb.pop_front();
                        check_output("rsp_data", rsp_data_o, e.data);
                        check_output("rsp_zero", rsp_zero_o, e.zero);
                        check_output("rsp_id", rsp_id_o, e.id);
                    end
                end
            end
            if (g0 || g1) begin
                e.id      = g1;
                e.op      = g1 ? req1_op_i : req0_op_i;
                e.a       = g1 ? req1_a_i : req0_a_i;
                e.b       = g1 ? req1_b_i : req0_b_i;
                e.data    = ref_alu(e.op, e.a, e.b);
                e.zero    = (e.a == e.b);
                e.acc_cyc = cyc;
                sb.push_back(e);
                model_last = g1;
            end
            prev_valid = rsp_valid_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_ready) rsp_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one or two requests and holds each valid until its handshake
    task automatic apply_stimulus(input bit v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                                  input bit v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                                  output int acc0);
        bit p0 = v0, p1 = v1, g0, g1;
        int n = 0;
        acc0 = -1;
        req0_op_i = o0; req0_a_i = a0; req0_b_i = b0;
        req1_op_i = o1; req1_a_i = a1; req1_b_i = b1;
        req0_valid_i = p0; req1_valid_i = p1;
        while ((p0 || p1) && n < 200) begin
            @(negedge clk_i);
            g0 = req0_valid_i && req0_ready_o;
            g1 = req1_valid_i && req1_ready_o;
            if (g0) acc0 = cyc;
            @(posedge clk_i);
            #1;
            if (g0) p0 = 0;
            if (g1) p1 = 0;
            req0_valid_i = p0; req1_valid_i = p1;
            n++;
        end
        check_output("accept_timeout", n >= 200, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_output("idle_timeout", n >= 300, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check_output("reset_ctrl", {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_zero_o, rsp_id_o, busy_o, alu_ctrl_o}, '0);
        check_output("reset_rsp_data", rsp_data_o, '0);
        check_output("reset_alu_data1", alu_data1_o, '0);
        check_output("reset_alu_data2", alu_data2_o, '0);
    endtask

    initial begin
        int c1, c2, c3, dummy, n;
        bit v0, v1;
        logic [31:0] a, b;

        #1;
        check_reset_outputs();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        rsp_ready_i = 1'b1;

        // Reset while the first op is in EXEC: it must vanish without a response
        req0_op_i = 3'b011; req0_a_i = 32'd100; req0_b_i = 32'd23; req0_valid_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!req0_ready_o && n < 20);
        @(posedge clk_i);
        #1 req0_valid_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        model_last = 1'b1; prev_valid = 0; prev_hold = 0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        apply_stimulus(1, 3'b011, 32'd5, 32'd7, 0, 3'b000, 0, 0, dummy);
        wait_idle();

        $display("[TB] zero flag from req1");
        apply_stimulus(0, 3'b000, 0, 0, 1, 3'b100, 32'h10, 32'h10, dummy);
        wait_idle();

        $display("[TB] tie arbitration");
        apply_stimulus(1, 3'b011, 32'd1, 32'd2, 1, 3'b100, 32'd9, 32'd4, dummy);
        wait_idle();
        apply_stimulus(1, 3'b001, 32'hA5A5, 32'h0F0F, 1, 3'b000, 32'hFF00, 32'h0FF0, dummy);
        wait_idle();

        $display("[TB] backpressure");
        rsp_ready_i = 1'b0;
        req0_op_i = 3'b011; req0_a_i = 32'd3; req0_b_i = 32'd4; req0_valid_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!req0_ready_o && n < 20);
        @(posedge clk_i);
        #1 req0_op_i = 3'b001; req0_a_i = 32'hF0; req0_b_i = 32'h0F;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rsp_valid_o && n < 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_output("bp_rsp_valid", rsp_valid_o, 1'b1);
            check_output("bp_rsp_data", rsp_data_o, 32'd7);
            check_output("bp_readys", {req0_ready_o, req1_ready_o}, 2'b00);
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!req0_ready_o && n < 20);
        check_output("bp_reaccept", req0_ready_o, 1'b1);
        @(posedge clk_i);
        #1 req0_valid_i = 1'b0;
        wait_idle();

        $display("[TB] MUL and SRAI");
        apply_stimulus(1, 3'b101, 32'd6, 32'd7, 0, 3'b000, 0, 0, dummy);
        wait_idle();
        apply_stimulus(1, 3'b111, 32'h8000_0000, 32'd4, 0, 3'b000, 0, 0, dummy);
        wait_idle();

        $display("[TB] XOR throughput");
        apply_stimulus(1, 3'b001, 32'h1234, 32'h00FF, 0, 3'b000, 0, 0, c1);
        apply_stimulus(1, 3'b001, 32'h5678, 32'hFF00, 0, 3'b000, 0, 0, c2);
        apply_stimulus(1, 3'b001, 32'h9ABC, 32'h0F0F, 0, 3'b000, 0, 0, c3);
        check_output("xor_spacing1", c2 - c1, 3);
        check_output("xor_spacing2", c3 - c2, 3);
        wait_idle();

        $display("[TB] random traffic");
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            apply_stimulus(v0, 3'($urandom_range(0, 7)), a, b,
                           v1, 3'($urandom_range(0, 7)), $urandom, $urandom, dummy);
        end
        rand_ready = 0;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester scheduler that time-shares the single 32-bit ALU between the execute stage and a secondary requester, such as the branch/address unit. It owns the ALU's operand and control inputs. It accepts one operation at a time through a valid/ready handshake, using round-robin arbitration. It captures the ALU result and zero flag into a response register, which holds them until the consumer takes them.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- MUL_LAT, 4, EXEC cycles for op 3'b101 (MUL) when ALU_ARB_MULCYC_EN is defined; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_valid_i / req1_valid_i  in  1  request valid; req0 is the execute stage.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid and ready are both high.
- req0_op_i / req1_op_i  in  3  ALU op: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
- req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  WIDTH  operands.
- alu_data1_o, alu_data2_o  out  WIDTH  operands driven to the ALU.
- alu_ctrl_o  out  3  op driven to the ALU.
- alu_data_i  in  WIDTH  ALU result.
- alu_zero_i  in  1  ALU zero flag (high when data1 == data2).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_data_o  out  WIDTH  captured result.
- rsp_zero_o  out  1  captured zero flag.
- rsp_id_o  out  1  requester that issued the op (0 or 1).
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The granted requester sees ready high; the other requester's ready is low.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the requester other than last_grant is granted.
  - On accept: register op, a, b and the requester id; update last_grant; go to EXEC.
- EXEC:
  - alu_data1_o, alu_data2_o and alu_ctrl_o are driven from the operand registers. They are held stable for the whole EXEC stay.
  - At the last EXEC cycle, capture alu_data_i and alu_zero_i into the response registers, then go to RESP.
- RESP:
  - rsp_valid_o is high; rsp_data_o, rsp_zero_o and rsp_id_o are held stable.
  - When rsp_ready_i is high, go to IDLE.
  - If rsp_ready_i is low, stay in RESP indefinitely with no change to any output.
- Both ready outputs are low in EXEC and RESP. No request is accepted in those states.
- In IDLE, alu_ctrl_o, alu_data1_o and alu_data2_o keep their last values; the ALU output is ignored.
- The block performs no arithmetic. Widths pass through unchanged, and the result is taken from the ALU bit-exact.

## Timing
- Reset (asynchronous assert):
  - State goes to IDLE and last_grant to 1, so req0 wins the first tie.
  - All outputs go to 0: both readys, rsp_*, alu_*, busy_o.
- Reset mid-operation: any in-flight op is discarded with no response. The first cycle after deassertion is IDLE.
- Latency for a single-cycle op: accept edge at cycle N; EXEC during cycle N+1; rsp_valid_o high from cycle N+2.
- Maximum throughput is one op per 3 cycles, with rsp_ready_i held high.
- ready_o depends combinationally on both valid inputs and the FSM state only. It never depends on rsp_ready_i.
- A requester dropping valid before it is accepted is legal and is not tracked.

## Configuration
- ALU_ARB_MULCYC_EN defined:
  - For MUL, EXEC lasts MUL_LAT cycles, counted by a 4-bit down-counter loaded at accept.
  - Capture happens in the cycle where the counter reaches 1.
  - Other ops still take 1 EXEC cycle.
- ALU_ARB_MULCYC_EN undefined: MUL_LAT is ignored; every op, MUL included, takes 1 EXEC cycle and no counter is built.

## Test plan
- Reset check: assert rst_i low mid-EXEC, then release. Required: all outputs are 0; next accept of ADD 5+7 gives rsp_data_o=12, rsp_id_o=0.
- Tie arbitration: both requesters hold valid; req0 ADD 1+2, req1 SUB 9-4. Required: responses in order id0=3 then id1=5. Issue a further tie; required: it grants req0 again.
- Zero flag: req1 issues SUB 0x10 - 0x10. Required: rsp_data_o=0, rsp_zero_o=1, rsp_id_o=1.
- Backpressure: hold rsp_ready_i low for 5 cycles with req0 valid throughout. Required: response is stable for all 5 cycles and both readys stay low; req0 is accepted only after the response handshake.
- MUL latency with macro on, MUL_LAT=4: req0 issues MUL 6*7. Required: rsp_valid_o is high 5 cycles after accept with data 42. With the macro off, required: 2 cycles.
- SRAI: req0 issues 0x80000000 >>> 4. Required: rsp_data_o=0xF8000000. Throughput: back-to-back XORs complete every 3 cycles.
